// File: rtl/bitlet_emax_tracker.sv
// bitlet_emax_tracker: per-frame extreme value and global index finder over N_IN-wide beats,
// using a registered compare tree followed by a frame accumulator.
module bitlet_emax_tracker #(
    parameter int N_IN      = 16,
    parameter int W         = 8,
    parameter int MAX_BEATS = 16
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 flush,
    input  logic                                 in_vld,
    input  logic                                 in_last,
    input  logic [1:0]                           in_mode,
    input  logic [N_IN*W-1:0]                    in_vec,
    output logic                                 out_vld,
    output logic [W-1:0]                         out_val,
    output logic [$clog2(MAX_BEATS*N_IN)-1:0]    out_idx,
    output logic                                 out_ovf
);
    localparam int LT  = $clog2(N_IN);
    localparam int LIW = (LT > 0) ? LT : 1;
    localparam int BW  = $clog2(MAX_BEATS);
    localparam int IW  = $clog2(MAX_BEATS*N_IN);

    typedef struct packed {
        logic          vld;
        logic          first;
        logic          last;
        logic          ovf;
        logic [1:0]    mode;
        logic [BW-1:0] beat;
    } sb_t;

    function automatic logic f_better(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] m);
        return m[0] ? (m[1] ? ($signed(a) < $signed(b)) : (a < b))
                    : (m[1] ? ($signed(a) > $signed(b)) : (a > b));
    endfunction

    // Heap layout: node i has children 2i/2i+1, leaves at N_IN..2*N_IN-1, root at 1.
    logic [W-1:0]   w_nv [2*N_IN];
    logic [LIW-1:0] w_ni [2*N_IN];
    sb_t            w_sb [LT+1];

    logic          r_in_frame;
    logic          r_full;
    logic [1:0]    r_mode;
    logic [BW-1:0] r_beat;
    logic          w_first;
    logic          w_acc;
    logic [1:0]    w_mode;
    logic [BW-1:0] w_beat;

    assign w_first = ~r_in_frame;
    assign w_acc   = in_vld & ~flush;
    assign w_mode  = w_first ? in_mode : r_mode;
    assign w_beat  = w_first ? '0 : r_beat;
    assign w_sb[0] = {w_acc, w_first, in_last, r_full, w_mode, w_beat};

    // r_full marks that beat MAX_BEATS-1 has been taken, so any further beat overflows.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_in_frame <= 1'b0;
            r_full     <= 1'b0;
            r_mode     <= '0;
            r_beat     <= '0;
        end else if (flush) begin
            r_in_frame <= 1'b0;
            r_full     <= 1'b0;
            r_beat     <= '0;
        end else if (in_vld) begin
            r_in_frame <= ~in_last;
            r_mode     <= w_mode;
            r_full     <= ~in_last & (r_full | (w_beat == BW'(MAX_BEATS-1)));
            r_beat     <= in_last ? '0 : ((w_beat == BW'(MAX_BEATS-1)) ? w_beat : w_beat + 1'b1);
        end
    end

    assign w_nv[0] = '0;
    assign w_ni[0] = '0;

    for (genvar k = 0; k < N_IN; k++) begin : g_leaf
        assign w_nv[N_IN+k] = in_vec[k*W +: W];
        assign w_ni[N_IN+k] = LIW'(k);
    end

    for (genvar l = 0; l < LT; l++) begin : g_l
        sb_t r_s;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) r_s <= '0;
            else        r_s <= flush ? '0 : w_sb[l];
        end
        assign w_sb[l+1] = r_s;
        for (genvar i = (N_IN >> (l+1)); i < (N_IN >> l); i++) begin : g_n
            logic [W-1:0]   r_v;
            logic [LIW-1:0] r_i;
            logic           w_r;
            // Right child wins only when strictly better, so ties go to the lower index.
            assign w_r = f_better(w_nv[2*i+1], w_nv[2*i], w_sb[l].mode);
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_v <= '0;
                    r_i <= '0;
                end else begin
                    r_v <= w_r ? w_nv[2*i+1] : w_nv[2*i];
                    r_i <= w_r ? w_ni[2*i+1] : w_ni[2*i];
                end
            end
            assign w_nv[i] = r_v;
            assign w_ni[i] = r_i;
        end
    end

    sb_t           w_t;
    logic [W-1:0]  r_acc_val;
    logic [IW-1:0] r_acc_idx;
    logic          r_acc_ovf;
    logic [IW-1:0] w_gidx;
    logic          w_take;
    logic [W-1:0]  w_val;
    logic [IW-1:0] w_idx;
    logic          w_ovf;
    logic          w_done;

    assign w_t    = w_sb[LT];
    assign w_gidx = IW'(w_t.beat) * IW'(N_IN) + IW'(w_ni[1]);
    assign w_take = w_t.first | f_better(w_nv[1], r_acc_val, w_t.mode);
    assign w_val  = w_take ? w_nv[1] : r_acc_val;
    assign w_idx  = w_take ? w_gidx : r_acc_idx;
    assign w_ovf  = w_t.ovf | (~w_t.first & r_acc_ovf);
    assign w_done = w_t.vld & w_t.last & ~flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc_val <= '0;
            r_acc_idx <= '0;
            r_acc_ovf <= 1'b0;
            out_vld   <= 1'b0;
            out_val   <= '0;
            out_idx   <= '0;
            out_ovf   <= 1'b0;
        end else begin
            out_vld <= w_done;
            if (flush) begin
                r_acc_val <= '0;
                r_acc_idx <= '0;
                r_acc_ovf <= 1'b0;
            end else if (w_t.vld) begin
                r_acc_val <= w_val;
                r_acc_idx <= w_idx;
                r_acc_ovf <= w_ovf;
            end
            if (w_done) begin
                out_val <= w_val;
                out_idx <= w_idx;
                out_ovf <= w_ovf;
            end
        end
    end
endmodule

// File: tb/tb_bitlet_emax_tracker.sv
// tb_bitlet_emax_tracker: directed frame table plus hand sequences for back-to-back,
// flush and async reset behaviour of bitlet_emax_tracker (N_IN=16, W=8, MAX_BEATS=16).
module tb_bitlet_emax_tracker;
    logic         clk;
    logic         rst_n;
    logic         flush;
    logic         in_vld;
    logic         in_last;
    logic [1:0]   in_mode;
    logic [127:0] in_vec;
    logic         out_vld;
    logic [7:0]   out_val;
    logic [7:0]   out_idx;
    logic         out_ovf;

    int n_tests = 0;
    int n_fail  = 0;

    bitlet_emax_tracker #(.N_IN(16), .W(8), .MAX_BEATS(16)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_vld(in_vld), .in_last(in_last),
        .in_mode(in_mode), .in_vec(in_vec), .out_vld(out_vld), .out_val(out_val),
        .out_idx(out_idx), .out_ovf(out_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] mode;
        int         nb;
        logic [7:0] fill;
        int         p0;
        logic [7:0] v0;
        int         p1;
        logic [7:0] v1;
        logic [7:0] e_val;
        int         e_idx;
        logic       e_ovf;
    } vec_t;

    vec_t tv [12];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [127:0] mk(input logic [7:0] fill, input int b, input int p0,
                                        input logic [7:0] v0, input int p1, input logic [7:0] v1);
        logic [127:0] r;
        for (int k = 0; k < 16; k++) begin
            int g;
            g = b*16 + k;
            r[k*8 +: 8] = (g == p0) ? v0 : ((g == p1) ? v1 : fill);
        end
        return r;
    endfunction

    task automatic beat(input logic [127:0] v, input logic [1:0] m, input logic last);
        in_vld  = 1'b1;
        in_vec  = v;
        in_mode = m;
        in_last = last;
        @(posedge clk);
        #1;
        in_vld  = 1'b0;
        in_last = 1'b0;
    endtask

    task automatic wait_res(output int c);
        c = 0;
        while (c < 30 && !out_vld) begin
            @(posedge clk);
            #1;
            c++;
        end
    endtask

    task automatic count_pulses(input int cycles, output int n, output logic [7:0] v,
                                output logic [7:0] ix, output logic o);
        n = 0; v = 0; ix = 0; o = 0;
        for (int c = 0; c < cycles; c++) begin
            @(posedge clk);
            #1;
            if (out_vld) begin
                n++; v = out_val; ix = out_idx; o = out_ovf;
            end
        end
    endtask

    initial begin
        int c;
        int np;
        logic [7:0] pv;
        logic [7:0] pi;
        logic       po;
        string nm;

        tv[0]  = '{2'b00,  4, 8'd100,  37, 8'd200,  -1, 8'd0,   8'd200, 37,  1'b0};
        tv[1]  = '{2'b00,  2, 8'd50,    3, 8'd90,   20, 8'd90,  8'd90,   3,  1'b0};
        tv[2]  = '{2'b00,  1, 8'd50,    9, 8'd90,   14, 8'd90,  8'd90,   9,  1'b0};
        tv[3]  = '{2'b11,  1, 8'h7F,    7, 8'h80,   -1, 8'd0,   8'h80,   7,  1'b0};
        tv[4]  = '{2'b00,  1, 8'h7F,    7, 8'h80,   -1, 8'd0,   8'h80,   7,  1'b0};
        tv[5]  = '{2'b10,  2, 8'hF0,   30, 8'h05,    2, 8'hFF,  8'h05,  30,  1'b0};
        tv[6]  = '{2'b01,  3, 8'd200,  40, 8'd3,    47, 8'd3,   8'd3,   40,  1'b0};
        tv[7]  = '{2'b00,  3, 8'd77,   -1, 8'd0,    -1, 8'd0,   8'd77,   0,  1'b0};
        tv[8]  = '{2'b11,  2, 8'h80,   -1, 8'd0,    -1, 8'd0,   8'h80,   0,  1'b0};
        tv[9]  = '{2'b00, 17, 8'd1,   258, 8'd9,    -1, 8'd0,   8'd9,  242,  1'b1};
        tv[10] = '{2'b00, 16, 8'd1,   255, 8'd9,    -1, 8'd0,   8'd9,  255,  1'b0};
        tv[11] = '{2'b00,  1, 8'd0,    15, 8'hFF,   -1, 8'd0,   8'hFF,  15,  1'b0};

        rst_n = 1'b0; flush = 1'b0; in_vld = 1'b0; in_last = 1'b0; in_mode = 2'b00; in_vec = '0;
        #12;
        chk("reset vld", out_vld, 0);
        chk("reset val", out_val, 0);
        chk("reset idx", out_idx, 0);
        chk("reset ovf", out_ovf, 0);
        @(posedge clk); #3; rst_n = 1'b1;
        @(posedge clk); #1;

        // Later beats carry the inverted mode to prove the frame mode is latched.
        for (int i = 0; i < 12; i++) begin
            nm = $sformatf("v%0d", i);
            for (int b = 0; b < tv[i].nb; b++)
                beat(mk(tv[i].fill, b, tv[i].p0, tv[i].v0, tv[i].p1, tv[i].v1),
                     (b == 0) ? tv[i].mode : ~tv[i].mode, b == tv[i].nb - 1);
            wait_res(c);
            chk({nm, " latency"}, c, 4);
            chk({nm, " val"}, out_val, tv[i].e_val);
            chk({nm, " idx"}, out_idx, tv[i].e_idx);
            chk({nm, " ovf"}, out_ovf, tv[i].e_ovf);
            @(posedge clk); #1;
            chk({nm, " pulse"}, out_vld, 0);
            chk({nm, " hold"}, out_val, tv[i].e_val);
        end

        // Back-to-back single-beat frames with differing modes.
        beat(mk(8'd3, 0, 6, 8'd10, 1, 8'h90), 2'b10, 1'b1);
        beat(mk(8'd20, 0, 11, 8'd50, -1, 8'd0), 2'b00, 1'b1);
        beat(mk(8'd5, 0, 4, 8'hFE, -1, 8'd0), 2'b11, 1'b1);
        @(posedge clk); #1;
        chk("b2b pre", out_vld, 0);
        @(posedge clk); #1;
        chk("b2b A vld", out_vld, 1);
        chk("b2b A val", out_val, 8'd10);
        chk("b2b A idx", out_idx, 6);
        @(posedge clk); #1;
        chk("b2b B vld", out_vld, 1);
        chk("b2b B val", out_val, 8'd50);
        chk("b2b B idx", out_idx, 11);
        @(posedge clk); #1;
        chk("b2b C vld", out_vld, 1);
        chk("b2b C val", out_val, 8'hFE);
        chk("b2b C idx", out_idx, 4);
        @(posedge clk); #1;
        chk("b2b post", out_vld, 0);

        // Flush mid-frame (same-cycle beat dropped), then flush an in-flight last beat.
        beat(mk(8'd99, 0, -1, 8'd0, -1, 8'd0), 2'b00, 1'b0);
        beat(mk(8'd99, 1, -1, 8'd0, -1, 8'd0), 2'b00, 1'b0);
        flush = 1'b1; in_vld = 1'b1; in_last = 1'b1; in_vec = {16{8'd200}};
        @(posedge clk); #1;
        flush = 1'b0; in_vld = 1'b0; in_last = 1'b0;
        beat(mk(8'd120, 0, -1, 8'd0, -1, 8'd0), 2'b00, 1'b1);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush vld", out_vld, 0);
        chk("flush hold val", out_val, 8'hFE);
        beat(mk(8'd7, 0, -1, 8'd0, -1, 8'd0), 2'b00, 1'b1);
        count_pulses(20, np, pv, pi, po);
        chk("flush pulses", np, 1);
        chk("flush val", pv, 8'd7);
        chk("flush idx", pi, 0);
        chk("flush ovf", po, 0);

        // Overflowing frame, then async reset with a frame in flight.
        for (int b = 0; b < 17; b++)
            beat(mk(8'd0, b, 9, 8'hEE, -1, 8'd0), 2'b00, b == 16);
        wait_res(c);
        chk("ovf17 latency", c, 4);
        chk("ovf17 val", out_val, 8'hEE);
        chk("ovf17 idx", out_idx, 9);
        chk("ovf17 ovf", out_ovf, 1);
        beat(mk(8'd1, 0, -1, 8'd0, -1, 8'd0), 2'b00, 1'b0);
        beat(mk(8'd1, 1, -1, 8'd0, -1, 8'd0), 2'b00, 1'b0);
        beat(mk(8'd5, 2, -1, 8'd0, -1, 8'd0), 2'b00, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst vld", out_vld, 0);
        chk("arst val", out_val, 0);
        chk("arst idx", out_idx, 0);
        chk("arst ovf", out_ovf, 0);
        @(posedge clk); @(posedge clk); #3;
        rst_n = 1'b1;
        count_pulses(15, np, pv, pi, po);
        chk("arst stale pulses", np, 0);
        beat(mk(8'd3, 0, -1, 8'd0, -1, 8'd0), 2'b01, 1'b1);
        wait_res(c);
        chk("post latency", c, 4);
        chk("post val", out_val, 8'd3);
        chk("post idx", out_idx, 0);
        chk("post ovf", out_ovf, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
